shifter_bist_driver: RTL and testbench
======================================

Name: shifter_bist_driver

Overview:
- On-chip stimulus generator and response checker for the 4-bit barrel shifter: the in-silicon counterpart of the simulation bench.
- Drives every operand/amount/direction combination into the shifter, compares each result against an internal golden model, and reports pass/fail, error count and first failing vector.
- Sits beside the shifter inside the user-project top; `start` and the status outputs map to the ui/uo pins.

Parameters:
- LAT, 0, shifter result latency in cycles (legal 0..3); the comparison is delayed by LAT.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset; the top drives it from ~rst_n
- start  input  1  begin a run; sampled only in IDLE or DONE
- dut_data  output  4  operand to shifter
- dut_amt  output  2  shift amount to shifter
- dut_dir  output  1  0 = rotate left, 1 = rotate right
- dut_result  input  4  shifter output, valid LAT cycles after its vector is issued
- busy  output  1  high in RUN/DRAIN
- done  output  1  high in DONE
- pass  output  1  high in DONE when err_count == 0
- err_count  output  8  mismatching vectors in current run
- fail_valid  output  1  at least one mismatch captured
- fail_idx  output  7  index of first mismatching vector
- sig  output  8  MISR signature (see Optional Feature)

Behaviour:
- Reset, sampled on a clk edge, forces IDLE and clears every output to 0, including the compare pipeline.
  - Reset mid-run abandons the run; no partial status is kept.
- Vector index `idx[6:0]` maps to dut_data = idx[3:0], dut_amt = idx[5:4], dut_dir = idx[6]. That gives 128 vectors, issued in ascending order.
- Golden model: expected = rotl(dut_data, dut_amt) when dir = 0, rotr(dut_data, dut_amt) when dir = 1, all 4-bit.
- FSM states IDLE, RUN, DRAIN, DONE. If start is sampled at cycle T:
  - IDLE/DONE with start = 1: go to RUN. Clear err_count, fail_valid, fail_idx, sig, done and pass.
  - RUN: cycles T+1..T+128 issue idx 0..127, one per cycle. After idx 127, go to DRAIN (LAT > 0) or DONE (LAT = 0).
  - DRAIN: stays LAT cycles, then goes to DONE.
  - DONE: done = 1 from cycle T+129+LAT. Outputs hold until start or rst.
  - start in RUN/DRAIN is ignored.
- Compare pipeline:
  - An expected value plus a valid bit travel LAT stages alongside each vector.
  - Vector k is compared against dut_result at cycle T+1+k+LAT.
- On mismatch:
  - err_count increments; maximum reachable value is 128, so no wrap.
  - On the first mismatch only: fail_idx = k and fail_valid = 1.
- pass is registered and asserts together with done.
- Between runs, dut_* hold their last issued values.
- In IDLE after reset, dut_* are 0.

Optional Feature:
- Macro: BIST_MISR_EN.
- Defined: an 8-bit MISR compacts every compared dut_result, taps x^8+x^4+x^3+x^2+1.
  - Per compare cycle: sig <= ({sig[6:0],1'b0} ^ (sig[7] ? 8'h1D : 8'h00)) ^ {4'b0, dut_result}.
  - Cleared at run start; frozen after the last compare.
- Undefined: sig is tied to 8'h00 and no MISR logic exists.

Test Plan:
- Correct shifter model, LAT = 1, start pulsed at T -> busy T+1..T+129, done = 1 and pass = 1 at T+130, err_count = 0, fail_valid = 0.
- Shifter result bit0 stuck at 0, LAT = 0 -> done at T+129, pass = 0, err_count = 64, fail_idx = 1, fail_valid = 1.
- Shifter with direction swapped (rotr for dir = 0 and vice versa), LAT = 2 -> err_count = 48, fail_idx = 17 (data 0001, amt 1, dir 0), pass = 0.
- rst asserted one cycle while issuing idx 50 -> next cycle all outputs 0 and state IDLE. A fresh start with a correct model then completes with pass = 1 and err_count = 0.
- start pulsed during RUN -> ignored, done still at T+129+LAT. start pulsed in DONE after a failing run -> done/pass/err_count/fail_valid clear next cycle and the new run proceeds.
- BIST_MISR_EN defined: two correct-model runs give an identical nonzero sig, and the bit0 stuck-at model gives a different sig. Undefined: sig = 8'h00 throughout.

Source files
------------

// File: rtl/shifter_bist_driver.sv
// shifter_bist_driver: exhaustive stimulus + golden-model checker for the 4-bit barrel shifter.
// Optional MISR signature compaction enabled by defining BIST_MISR_EN (sig tied to 0 otherwise).
module shifter_bist_driver #(
  parameter int LAT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] dut_data,
  output logic [1:0] dut_amt,
  output logic       dut_dir,
  input  logic [3:0] dut_result,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic       fail_valid,
  output logic [6:0] fail_idx,
  output logic [7:0] sig
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [1:0] DRAIN_LAST = (LAT > 0) ? 2'(LAT - 1) : 2'd0;

  state_t     state;
  state_t     state_n;
  logic [6:0] idx;
  logic [1:0] drain_cnt;
  logic       go;
  logic       enter_done;

  logic       iss_v;
  logic [3:0] iss_e;
  logic [6:0] iss_k;
  logic       cmp_v;
  logic [3:0] cmp_e;
  logic [6:0] cmp_k;
  logic       mismatch;
  logic [7:0] err_next;

  function automatic logic [3:0] golden(input logic [6:0] v);
    logic [7:0] dd;
    logic [7:0] sh;
    dd = {v[3:0], v[3:0]};
    if (v[6]) begin
      sh = dd >> v[5:4];
      return sh[3:0];
    end
    sh = dd << v[5:4];
    return sh[7:4];
  endfunction

  assign go         = start && (state == S_IDLE || state == S_DONE);
  assign enter_done = (state_n == S_DONE) && (state != S_DONE);

  // The vector index doubles as the stimulus; it holds between runs.
  assign {dut_dir, dut_amt, dut_data} = idx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start) state_n = S_RUN;
      S_RUN: begin
        if (idx == 7'd127) state_n = (LAT > 0) ? S_DRAIN : S_DONE;
      end
      S_DRAIN: if (drain_cnt == DRAIN_LAST) state_n = S_DONE;
      S_DONE:  if (start) state_n = S_RUN;
      default: state_n = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy = (state == S_RUN) || (state == S_DRAIN);
    done = (state == S_DONE);
  end

  // Vector index and drain counter
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      drain_cnt <= '0;
    end else begin
      if (go) idx <= '0;
      else if (state == S_RUN && idx != 7'd127) idx <= idx + 7'd1;
      if (state == S_DRAIN) drain_cnt <= drain_cnt + 2'd1;
      else                  drain_cnt <= '0;
    end
  end

  assign iss_v = (state == S_RUN);
  assign iss_e = golden(idx);
  assign iss_k = idx;

  // Expected value and index travel alongside the shifter's latency.
  generate
    if (LAT == 0) begin : g_nopipe
      assign cmp_v = iss_v;
      assign cmp_e = iss_e;
      assign cmp_k = iss_k;
    end else begin : g_pipe
      logic       v_p [1:LAT];
      logic [3:0] e_p [1:LAT];
      logic [6:0] k_p [1:LAT];
      // Compare-pipeline shift register
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 1; i <= LAT; i++) begin
            v_p[i] <= 1'b0;
            e_p[i] <= '0;
            k_p[i] <= '0;
          end
        end else begin
          v_p[1] <= iss_v;
          e_p[1] <= iss_e;
          k_p[1] <= iss_k;
          for (int i = 2; i <= LAT; i++) begin
            v_p[i] <= v_p[i-1];
            e_p[i] <= e_p[i-1];
            k_p[i] <= k_p[i-1];
          end
        end
      end
      assign cmp_v = v_p[LAT];
      assign cmp_e = e_p[LAT];
      assign cmp_k = k_p[LAT];
    end
  endgenerate

  assign mismatch = cmp_v && (dut_result != cmp_e);
  assign err_next = err_count + 8'(mismatch);

  // Run status: error count, first failure, pass flag
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_idx   <= '0;
      pass       <= 1'b0;
    end else if (go) begin
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_idx   <= '0;
      pass       <= 1'b0;
    end else begin
      if (mismatch) begin
        err_count <= err_next;
        if (!fail_valid) begin
          fail_valid <= 1'b1;
          fail_idx   <= cmp_k;
        end
      end
      if (enter_done) pass <= (err_next == 8'd0);
    end
  end

`ifdef BIST_MISR_EN
  // MISR over every compared result, x^8+x^4+x^3+x^2+1
  always_ff @(posedge clk) begin
    if (rst || go) begin
      sig <= '0;
    end else if (cmp_v) begin
      sig <= ({sig[6:0], 1'b0} ^ (sig[7] ? 8'h1D : 8'h00)) ^ {4'b0, dut_result};
    end
  end
`else
  assign sig = 8'h00;
`endif

endmodule

// File: tb/tb_shifter_bist_driver.sv
// tb_shifter_bist_driver: runs three BIST instances (LAT 0/1/2) against
// behavioural shifter models with injectable faults.
module tb_shifter_bist_driver;

  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  logic [3:0] d_data [3];
  logic [1:0] d_amt  [3];
  logic       d_dir  [3];
  logic       busy   [3];
  logic       done   [3];
  logic       pass   [3];
  logic       fvalid [3];
  logic [7:0] errc   [3];
  logic [7:0] sig    [3];
  logic [6:0] fidx   [3];
  logic [3:0] res0, res1, res2, s2;

  int lat_of [3] = '{0, 1, 2};
  int mode, sb;
  int checks = 0;
  int errors = 0;

  shifter_bist_driver #(.LAT(0)) u0 (
    .clk(clk), .rst(rst), .start(start),
    .dut_data(d_data[0]), .dut_amt(d_amt[0]), .dut_dir(d_dir[0]),
    .dut_result(res0), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(errc[0]), .fail_valid(fvalid[0]), .fail_idx(fidx[0]),
    .sig(sig[0]));
  shifter_bist_driver #(.LAT(1)) u1 (
    .clk(clk), .rst(rst), .start(start),
    .dut_data(d_data[1]), .dut_amt(d_amt[1]), .dut_dir(d_dir[1]),
    .dut_result(res1), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(errc[1]), .fail_valid(fvalid[1]), .fail_idx(fidx[1]),
    .sig(sig[1]));
  shifter_bist_driver #(.LAT(2)) u2 (
    .clk(clk), .rst(rst), .start(start),
    .dut_data(d_data[2]), .dut_amt(d_amt[2]), .dut_dir(d_dir[2]),
    .dut_result(res2), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .err_count(errc[2]), .fail_valid(fvalid[2]), .fail_idx(fidx[2]),
    .sig(sig[2]));

  // Ideal rotation: result bit i comes from data bit (i -/+ a) mod 4
  function automatic logic [3:0] ideal(input logic [3:0] d, input int a, input bit r);
    logic [3:0] y;
    for (int i = 0; i < 4; i++) y[i] = d[r ? (i + a) % 4 : (i + 4 - a) % 4];
    return y;
  endfunction

  // Shifter behaviour: 0 ok, 1 bit b stuck 0, 2 direction swapped, 3 bit b stuck 1
  function automatic logic [3:0] shf(input int m, input int b, input logic [3:0] d,
                                     input int a, input bit r);
    logic [3:0] y;
    y = ideal(d, a, (m == 2) ? !r : r);
    if (m == 1) y[b] = 1'b0;
    if (m == 3) y[b] = 1'b1;
    return y;
  endfunction

  always_comb res0 = shf(mode, sb, d_data[0], int'(d_amt[0]), d_dir[0]);
  always @(posedge clk) res1 <= shf(mode, sb, d_data[1], int'(d_amt[1]), d_dir[1]);
  always @(posedge clk) begin
    s2   <= shf(mode, sb, d_data[2], int'(d_amt[2]), d_dir[2]);
    res2 <= s2;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Whole-run reference: walk all 128 vectors in order
  task automatic ref_run(input int m, input int b, output int err, output int fi,
                         output int fv, output int s);
    logic [3:0] got;
    err = 0; fi = 0; fv = 0; s = 0;
    for (int k = 0; k < 128; k++) begin
      got = shf(m, b, 4'(k % 16), (k / 16) % 4, bit'(k / 64));
      if (got != ideal(4'(k % 16), (k / 16) % 4, bit'(k / 64))) begin
        err++;
        if (fv == 0) begin fi = k; fv = 1; end
      end
      s = (((s * 2) % 256) ^ ((s >= 128) ? 29 : 0)) ^ int'(got);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_vec%0d", tag, i), int'({d_dir[i], d_amt[i], d_data[i]}), 0);
      chk($sformatf("%s_stat%0d", tag, i),
          int'({busy[i], done[i], pass[i], fvalid[i]}), 0);
      chk($sformatf("%s_err%0d", tag, i), int'(errc[i]), 0);
      chk($sformatf("%s_fidx%0d", tag, i), int'(fidx[i]), 0);
      chk($sformatf("%s_sig%0d", tag, i), int'(sig[i]), 0);
    end
  endtask

  task automatic run(input int m, input int b, input bit poke);
    int n, all, e_err, e_fi, e_fv, e_sig;
    int done_at [3];
    int bcnt [3];
    ref_run(m, b, e_err, e_fi, e_fv, e_sig);
`ifndef BIST_MISR_EN
    e_sig = 0;
`endif
    mode = m; sb = b;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("start_clear%0d", i),
          int'({done[i], pass[i], fvalid[i], errc[i]}), 0);
      chk($sformatf("start_busy%0d", i), int'(busy[i]), 1);
      done_at[i] = -1; bcnt[i] = 0;
    end
    n = 0; all = 0;
    while (n < 300 && all == 0) begin
      all = 1;
      for (int i = 0; i < 3; i++) begin
        if (busy[i]) bcnt[i]++;
        if (done[i] && done_at[i] < 0) done_at[i] = n;
        if (done_at[i] < 0) all = 0;
      end
      start = (poke && n == 40);
      @(negedge clk); n++;
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("done_time%0d", i), done_at[i], 128 + lat_of[i]);
      chk($sformatf("busy_len%0d", i), bcnt[i], 128 + lat_of[i]);
      chk($sformatf("err%0d", i), int'(errc[i]), e_err);
      chk($sformatf("fidx%0d", i), int'(fidx[i]), e_fi);
      chk($sformatf("fvalid%0d", i), int'(fvalid[i]), e_fv);
      chk($sformatf("pass%0d", i), int'(pass[i]), (e_err == 0) ? 1 : 0);
      chk($sformatf("sig%0d", i), int'(sig[i]), e_sig);
    end
  endtask

  typedef struct {
    int m; int b; bit poke;
    int err; int fi; int fv; int ps;
  } vec_t;

  vec_t tbl [6];
  int   sigs [6];

  initial begin
    tbl[0] = '{0, 0, 1'b0, 0,  0,  0, 1};
    tbl[1] = '{1, 0, 1'b1, 64, 1,  1, 0};
    tbl[2] = '{2, 0, 1'b0, 48, 17, 1, 0};
    tbl[3] = '{3, 0, 1'b0, 64, 0,  1, 0};
    tbl[4] = '{1, 3, 1'b0, 64, 8,  1, 0};
    tbl[5] = '{0, 0, 1'b0, 0,  0,  0, 1};

    rst = 1'b1; start = 1'b0; mode = 0; sb = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_zero("reset");

    for (int t = 0; t < 6; t++) begin
      run(tbl[t].m, tbl[t].b, tbl[t].poke);
      sigs[t] = int'(sig[0]);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("tbl%0d_err%0d", t, i), int'(errc[i]), tbl[t].err);
        chk($sformatf("tbl%0d_fidx%0d", t, i), int'(fidx[i]), tbl[t].fi);
        chk($sformatf("tbl%0d_fv%0d", t, i), int'(fvalid[i]), tbl[t].fv);
        chk($sformatf("tbl%0d_pass%0d", t, i), int'(pass[i]), tbl[t].ps);
      end
    end
`ifdef BIST_MISR_EN
    chk("misr_repeat", sigs[5], sigs[0]);
    chk("misr_nonzero", int'(sigs[0] != 0), 1);
    chk("misr_differs", int'(sigs[1] != sigs[0]), 1);
`else
    for (int t = 0; t < 6; t++) chk($sformatf("sig_tied%0d", t), sigs[t], 0);
`endif

    // Reset while vector 50 is being issued
    mode = 0; sb = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (50) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("mid_vec%0d", i), int'({d_dir[i], d_amt[i], d_data[i]}), 50);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk_zero("midrst");
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("stay_idle%0d", i), int'({busy[i], done[i]}), 0);
    run(0, 0, 1'b0);

    for (int r = 0; r < 6; r++)
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
